// File: rtl/ledger_pkg.sv
// Shared widths, FSM states and response codes for the stock ledger.
package ledger_pkg;

    localparam int unsigned SLOTS   = 4;
    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned CT_W    = 4;
    localparam int unsigned PRICE_W = 4;
    localparam int unsigned TOTAL_W = 8;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned STEP_W  = 2;

    localparam logic [CODE_W-1:0] RC_OK          = 2'd0;
    localparam logic [CODE_W-1:0] RC_SHORT_STOCK = 2'd1;
    localparam logic [CODE_W-1:0] RC_TILL_SHORT  = 2'd2;
    localparam logic [CODE_W-1:0] RC_OVERFLOW    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_multiplier_4bit.sv
// Shift-add 4x4->8 multiplier: one multiplier bit per cycle, LSB first.
module seq_multiplier_4bit
    import ledger_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [PRICE_W-1:0] mcand,
    input  logic [PRICE_W-1:0] mplier,
    output logic               done_c,
    output logic [TOTAL_W-1:0] product
);

    logic [PRICE_W-1:0] a_q;
    logic [PRICE_W-1:0] b_q;
    logic [STEP_W-1:0]  step_q;
    logic               busy_q;

    // Last partial product is being accumulated this cycle.
    assign done_c = busy_q && (step_q == STEP_W'(3));

    // Operand capture on start, then one conditional add per step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            product <= '0;
        end else if (start) begin
            a_q     <= mcand;
            b_q     <= mplier;
            step_q  <= '0;
            busy_q  <= 1'b1;
            product <= '0;
        end else if (busy_q) begin
            if (b_q[step_q]) begin
                product <= product + (TOTAL_W'(a_q) << step_q);
            end
            step_q <= step_q + STEP_W'(1);
            busy_q <= (step_q != STEP_W'(3));
        end
    end

endmodule

// File: rtl/stock_ledger.sv
// Per-slot stock/price store and till keeper with request/response handshakes.
module stock_ledger
    import ledger_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [SLOT_W-1:0]  cfg_slot,
    input  logic [PRICE_W-1:0] cfg_uprice,
    input  logic [CT_W-1:0]    cfg_count,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SLOT_W-1:0]  req_slot,
    input  logic               req_ctrl,
    input  logic [PRICE_W-1:0] req_ncel,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [CODE_W-1:0]  resp_code,
    output logic [TOTAL_W-1:0] resp_fprice,
    output logic [CT_W-1:0]    resp_new_ct,
    output logic [TOTAL_W-1:0] total,
    output logic [SLOTS-1:0]   empty
);

    state_t state_q, state_d;

    logic [CT_W-1:0]    count_q [SLOTS];
    logic [PRICE_W-1:0] price_q [SLOTS];
    logic [SLOT_W-1:0]  slot_q;
    logic               ctrl_q;
    logic [PRICE_W-1:0] ncel_q;
    logic [CT_W-1:0]    cnt_q;

    logic               mul_start;
    logic               mul_done_c;
    logic [TOTAL_W-1:0] product;

    logic [CODE_W-1:0]  code_c;
    logic [CT_W:0]      ct_sum;
    logic [TOTAL_W:0]   tot_sum;
    logic [CT_W-1:0]    new_ct;

    seq_multiplier_4bit u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .mcand   (price_q[req_slot]),
        .mplier  (req_ncel),
        .done_c  (mul_done_c),
        .product (product)
    );

    assign resp_valid = (state_q == RESP);

    // Per-slot empty flags straight from the stored counts.
    always_comb begin
        empty = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            empty[i] = (count_q[i] == '0);
        end
    end

    // Next state, handshake and prioritised transaction check.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mul_start = 1'b0;
        code_c    = RC_OK;
        ct_sum    = {1'b0, cnt_q} + {1'b0, ncel_q};
        tot_sum   = {1'b0, total} + {1'b0, product};
        new_ct    = ctrl_q ? (cnt_q - ncel_q) : (cnt_q + ncel_q);

        if (ctrl_q && (ncel_q > cnt_q)) begin
            code_c = RC_SHORT_STOCK;
        end else if (!ctrl_q && (product > total)) begin
            code_c = RC_TILL_SHORT;
        end else if ((!ctrl_q && ct_sum[CT_W]) || (ctrl_q && tot_sum[TOTAL_W])) begin
            code_c = RC_OVERFLOW;
        end

        case (state_q)
            IDLE: begin
                req_ready = !cfg_we;
                if (!cfg_we && req_valid) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (mul_done_c) state_d = CHECK;
            end
            CHECK:   state_d = RESP;
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Slot storage, request latch, commit and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                count_q[i] <= '0;
                price_q[i] <= '0;
            end
            total       <= '0;
            slot_q      <= '0;
            ctrl_q      <= 1'b0;
            ncel_q      <= '0;
            cnt_q       <= '0;
            resp_code   <= RC_OK;
            resp_fprice <= '0;
            resp_new_ct <= '0;
        end else begin
            if ((state_q == IDLE) && cfg_we) begin
                count_q[cfg_slot] <= cfg_count;
                price_q[cfg_slot] <= cfg_uprice;
            end
            if (mul_start) begin
                slot_q <= req_slot;
                ctrl_q <= req_ctrl;
                ncel_q <= req_ncel;
                cnt_q  <= count_q[req_slot];
            end
            if (state_q == CHECK) begin
                resp_code <= code_c;
                if (code_c == RC_OK) begin
                    resp_fprice     <= product;
                    resp_new_ct     <= new_ct;
                    count_q[slot_q] <= new_ct;
                    total           <= ctrl_q ? (total + product) : (total - product);
                end else begin
                    resp_fprice <= '0;
                    resp_new_ct <= cnt_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_stock_ledger.sv
// Directed self-checking bench for stock_ledger.
module tb_stock_ledger;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cfg_we;
    logic [1:0] cfg_slot;
    logic [3:0] cfg_uprice;
    logic [3:0] cfg_count;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_slot;
    logic       req_ctrl;
    logic [3:0] req_ncel;
    logic       resp_valid;
    logic       resp_ready;
    logic [1:0] resp_code;
    logic [7:0] resp_fprice;
    logic [3:0] resp_new_ct;
    logic [7:0] total;
    logic [3:0] empty;

    int n_pass  = 0;
    int n_total = 0;

    stock_ledger dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_slot    (cfg_slot),
        .cfg_uprice  (cfg_uprice),
        .cfg_count   (cfg_count),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_slot    (req_slot),
        .req_ctrl    (req_ctrl),
        .req_ncel    (req_ncel),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_code   (resp_code),
        .resp_fprice (resp_fprice),
        .resp_new_ct (resp_new_ct),
        .total       (total),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] s, input logic [3:0] p, input logic [3:0] c);
        cfg_we = 1'b1; cfg_slot = s; cfg_uprice = p; cfg_count = c;
        step();
        cfg_we = 1'b0;
    endtask

    // Issue one request, wait (bounded) for the response, capture it, handshake.
    task automatic run_txn(input logic [1:0] s, input logic c, input logic [3:0] n,
                           output int lat, output logic [1:0] code,
                           output logic [7:0] fp, output logic [3:0] ct);
        req_slot = s; req_ctrl = c; req_ncel = n; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        code = resp_code; fp = resp_fprice; ct = resp_new_ct;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({req_ready, resp_valid, resp_code, resp_fprice, resp_new_ct, total, empty}
            !== {1'b1, 1'b0, 2'd0, 8'd0, 4'd0, 8'd0, 4'b1111}) begin
            $display("FAIL reset_outputs: rdy=%0b vld=%0b code=%0d fp=%0d ct=%0d tot=%0d empty=%b, want 1 0 0 0 0 0 1111",
                     req_ready, resp_valid, resp_code, resp_fprice, resp_new_ct, total, empty);
        end else n_pass++;
    endtask

    task automatic test_sale();
        int lat; logic [1:0] code; logic [7:0] fp; logic [3:0] ct;
        cfg(2'd1, 4'd3, 4'd5);
        n_total++;
        if (empty !== 4'b1101) $display("FAIL cfg_empty: got %b want 1101", empty);
        else n_pass++;
        run_txn(2'd1, 1'b1, 4'd2, lat, code, fp, ct);
        n_total++;
        if (lat !== 5) $display("FAIL sale_latency: got %0d want 5", lat);
        else n_pass++;
        n_total++;
        if ({code, fp, ct, total, empty} !== {2'd0, 8'd6, 4'd3, 8'd6, 4'b1101})
            $display("FAIL sale_result: code=%0d fp=%0d ct=%0d tot=%0d empty=%b want 0 6 3 6 1101",
                     code, fp, ct, total, empty);
        else n_pass++;
    endtask

    task automatic test_short_stock();
        int lat; logic [1:0] code; logic [7:0] fp; logic [3:0] ct;
        run_txn(2'd1, 1'b1, 4'd4, lat, code, fp, ct);
        n_total++;
        if ({code, fp, ct, total} !== {2'd1, 8'd0, 4'd3, 8'd6})
            $display("FAIL short_stock: code=%0d fp=%0d ct=%0d tot=%0d want 1 0 3 6", code, fp, ct, total);
        else n_pass++;
        n_total++;
        if (lat !== 5) $display("FAIL reject_latency: got %0d want 5", lat);
        else n_pass++;
    endtask

    task automatic test_restock();
        int lat; logic [1:0] code; logic [7:0] fp; logic [3:0] ct;
        run_txn(2'd1, 1'b0, 4'd3, lat, code, fp, ct);
        n_total++;
        if ({code, fp, ct, total} !== {2'd2, 8'd0, 4'd3, 8'd6})
            $display("FAIL till_short: code=%0d fp=%0d ct=%0d tot=%0d want 2 0 3 6", code, fp, ct, total);
        else n_pass++;
        run_txn(2'd1, 1'b0, 4'd2, lat, code, fp, ct);
        n_total++;
        if ({code, fp, ct, total} !== {2'd0, 8'd6, 4'd5, 8'd0})
            $display("FAIL restock_ok: code=%0d fp=%0d ct=%0d tot=%0d want 0 6 5 0", code, fp, ct, total);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int lat; logic [1:0] code; logic [7:0] fp; logic [3:0] ct;
        cfg(2'd0, 4'd15, 4'd15);
        cfg(2'd2, 4'd10, 4'd4);
        run_txn(2'd2, 1'b1, 4'd4, lat, code, fp, ct);
        n_total++;
        if ({code, fp, ct, total, empty} !== {2'd0, 8'd40, 4'd0, 8'd40, 4'b1100})
            $display("FAIL sell_out: code=%0d fp=%0d ct=%0d tot=%0d empty=%b want 0 40 0 40 1100",
                     code, fp, ct, total, empty);
        else n_pass++;
        run_txn(2'd0, 1'b1, 4'd15, lat, code, fp, ct);
        n_total++;
        if ({code, fp, ct, total} !== {2'd3, 8'd0, 4'd15, 8'd40})
            $display("FAIL till_overflow: code=%0d fp=%0d ct=%0d tot=%0d want 3 0 15 40", code, fp, ct, total);
        else n_pass++;
        run_txn(2'd0, 1'b0, 4'd1, lat, code, fp, ct);
        n_total++;
        if ({code, fp, ct, total} !== {2'd3, 8'd0, 4'd15, 8'd40})
            $display("FAIL count_overflow: code=%0d fp=%0d ct=%0d tot=%0d want 3 0 15 40", code, fp, ct, total);
        else n_pass++;
        run_txn(2'd1, 1'b1, 4'd0, lat, code, fp, ct);
        n_total++;
        if ({code, fp, ct, total} !== {2'd0, 8'd0, 4'd5, 8'd40})
            $display("FAIL zero_qty: code=%0d fp=%0d ct=%0d tot=%0d want 0 0 5 40", code, fp, ct, total);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        req_slot = 2'd1; req_ctrl = 1'b1; req_ncel = 4'd1; req_valid = 1'b1;
        step();
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        n_total++;
        if (lat !== 5) $display("FAIL hold_latency: got %0d want 5", lat);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if ({resp_valid, req_ready, resp_code, resp_fprice, resp_new_ct, total}
                !== {1'b1, 1'b0, 2'd0, 8'd3, 4'd4, 8'd43})
                $display("FAIL hold_cycle%0d: vld=%0b rdy=%0b code=%0d fp=%0d ct=%0d tot=%0d want 1 0 0 3 4 43",
                         i, resp_valid, req_ready, resp_code, resp_fprice, resp_new_ct, total);
            else n_pass++;
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_total++;
        if ({resp_valid, req_ready} !== {1'b0, 1'b1})
            $display("FAIL after_handshake: vld=%0b rdy=%0b want 0 1", resp_valid, req_ready);
        else n_pass++;
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        n_total++;
        if ({lat[4:0], resp_code, resp_fprice, resp_new_ct, total} !== {5'd5, 2'd0, 8'd3, 4'd3, 8'd46})
            $display("FAIL second_txn: lat=%0d code=%0d fp=%0d ct=%0d tot=%0d want 5 0 3 3 46",
                     lat, resp_code, resp_fprice, resp_new_ct, total);
        else n_pass++;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        req_slot = 2'd1; req_ctrl = 1'b1; req_ncel = 4'd2; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({req_ready, resp_valid, resp_code, resp_fprice, resp_new_ct, total, empty}
            !== {1'b1, 1'b0, 2'd0, 8'd0, 4'd0, 8'd0, 4'b1111})
            $display("FAIL midreset_outputs: rdy=%0b vld=%0b code=%0d fp=%0d ct=%0d tot=%0d empty=%b want 1 0 0 0 0 0 1111",
                     req_ready, resp_valid, resp_code, resp_fprice, resp_new_ct, total, empty);
        else n_pass++;
        step();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if ({req_ready, resp_valid, total, empty} !== {1'b1, 1'b0, 8'd0, 4'b1111}) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL midreset_no_commit: bad_cycles=%0d want 0", bad);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_uprice = '0; cfg_count = '0;
        req_valid = 1'b0; req_slot = '0; req_ctrl = 1'b0; req_ncel = '0; resp_ready = 1'b0;
        step();
        step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_reset();
        test_sale();
        test_short_stock();
        test_restock();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
